// File: rtl/digit_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_driver
// Purpose  : 640x480@60 raster scan driver for the MM:SS:CC stopwatch display.
//            Generates VGA timing from the pixel clock and, per pixel, presents
//            cell-local coordinates and a digit code to an external glyph
//            renderer. Combines the renderer's lit flag into a registered
//            RGB444 pixel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1   pixel clock (25 MHz)
//   rst       in   1   synchronous, active-high reset
//   time_bcd  in  24   {M1,M0,S1,S0,C1,C0} BCD digits, M1 leftmost
//   f         in   1   lit flag from renderer (combinational of x, y, d)
//   x         out 10   cell-local x (0..39), 0 outside any cell
//   y         out 10   cell-local y (0..79), 0 outside any cell
//   d         out  4   digit code of current cell, 4'hF outside any cell
//   hsync     out  1   horizontal sync, active low
//   vsync     out  1   vertical sync, active low
//   rgb       out 12   pixel colour, 0 during blanking
// ----------------------------------------------------------------------------
// Build option
//   COLON_EN  when defined, two 8x8 colon dots are drawn in each of the two
//             separator gaps; otherwise the gaps show the background colour.
// ----------------------------------------------------------------------------
// Pipeline
//   stage 0 : h/v counters
//   stage 1 : x, y, d, active, colon hit, sync (registered)
//   stage 2 : rgb, hsync, vsync (registered) -> 2 clocks after the counters
//   The renderer must sit combinationally between x/y/d and f.
// ============================================================================
module digit_scan_driver #(
    parameter int          X0 = 160,
    parameter int          Y0 = 200,
    parameter logic [11:0] FG = 12'hFFF,
    parameter logic [11:0] BG = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic        f,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [3:0]  d,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    // ------------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------------
    localparam logic [9:0] c_H_LAST   = 10'd799;
    localparam logic [9:0] c_V_LAST   = 10'd524;
    localparam logic [9:0] c_H_ACTIVE = 10'd640;
    localparam logic [9:0] c_V_ACTIVE = 10'd480;
    localparam logic [9:0] c_HS_START = 10'd656;
    localparam logic [9:0] c_HS_LEN   = 10'd96;
    localparam logic [9:0] c_VS_START = 10'd490;
    localparam logic [9:0] c_VS_LEN   = 10'd2;
    localparam logic [9:0] c_LATCH_V  = 10'd480;

    localparam logic [9:0] c_CELL_W   = 10'd40;
    localparam logic [9:0] c_CELL_H   = 10'd80;
    localparam logic [9:0] c_Y_TOP    = 10'(Y0);

    localparam logic [3:0] c_NO_DIGIT = 4'hF;
    localparam int         c_NCELLS   = 6;

    // Horizontal offset of each digit cell from X0, left to right.
    localparam int c_CELL_OFF [c_NCELLS] = '{0, 48, 112, 160, 224, 272};

    // True when v lies in [lo, lo+len). The subtraction wraps for v < lo,
    // so the explicit lower-bound test keeps the intent obvious.
    function automatic logic in_span(
        input logic [9:0] v,
        input logic [9:0] lo,
        input logic [9:0] len
    );
        return (v >= lo) && ((v - lo) < len);
    endfunction

    // ------------------------------------------------------------------------
    // Stage 0: raster counters
    // ------------------------------------------------------------------------
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        w_h_wrap;

    assign w_h_wrap = (r_h == c_H_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame latch: the digits are sampled once, at the start of the first
    // blank line, so a whole visible frame always shows one consistent value.
    // ------------------------------------------------------------------------
    logic [23:0] r_digits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= '0;
        end else if ((r_h == '0) && (r_v == c_LATCH_V)) begin
            r_digits <= time_bcd;
        end
    end

    // ------------------------------------------------------------------------
    // Stage-1 decode (combinational from the counters)
    // ------------------------------------------------------------------------
    logic       w_active;
    logic       w_row_hit;
    logic       w_hs;
    logic       w_vs;
    logic       w_colon;
    logic [5:0] w_cell_hit;
    logic [9:0] w_cell_dx    [c_NCELLS];
    logic [3:0] w_cell_digit [c_NCELLS];
    logic [9:0] w_x;
    logic [9:0] w_y;
    logic [3:0] w_d;

    assign w_active  = (r_h < c_H_ACTIVE) && (r_v < c_V_ACTIVE);
    assign w_row_hit = w_active && in_span(r_v, c_Y_TOP, c_CELL_H);
    assign w_hs      = ~in_span(r_h, c_HS_START, c_HS_LEN);
    assign w_vs      = ~in_span(r_v, c_VS_START, c_VS_LEN);

    for (genvar gi = 0; gi < c_NCELLS; gi++) begin : g_cell
        localparam logic [9:0] c_START = 10'(X0 + c_CELL_OFF[gi]);
        assign w_cell_dx[gi]    = r_h - c_START;
        assign w_cell_hit[gi]   = w_row_hit && in_span(r_h, c_START, c_CELL_W);
        // Cell 0 takes the most significant nibble (M1).
        assign w_cell_digit[gi] = r_digits[23 - 4*gi -: 4];
    end

    // Cells never overlap, so at most one hit bit is set at a time.
    always_comb begin
        w_x = '0;
        w_y = '0;
        w_d = c_NO_DIGIT;
        for (int i = 0; i < c_NCELLS; i++) begin
            if (w_cell_hit[i]) begin
                w_x = w_cell_dx[i];
                w_y = r_v - c_Y_TOP;
                w_d = w_cell_digit[i];
            end
        end
    end

`ifdef COLON_EN
    // Colon dots: 8x8 squares in each separator gap, two per gap.
    localparam logic [9:0] c_SEP1_X = 10'(X0 + 96);
    localparam logic [9:0] c_SEP2_X = 10'(X0 + 208);
    localparam logic [9:0] c_DOT1_Y = 10'(Y0 + 20);
    localparam logic [9:0] c_DOT2_Y = 10'(Y0 + 52);
    localparam logic [9:0] c_DOT_SZ = 10'd8;

    logic w_colon_x;
    logic w_colon_y;

    assign w_colon_x = in_span(r_h, c_SEP1_X, c_DOT_SZ) || in_span(r_h, c_SEP2_X, c_DOT_SZ);
    assign w_colon_y = in_span(r_v, c_DOT1_Y, c_DOT_SZ) || in_span(r_v, c_DOT2_Y, c_DOT_SZ);
    assign w_colon   = w_active && w_colon_x && w_colon_y;
`else
    assign w_colon   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Stage 1 registers: feed the renderer and the colour stage
    // ------------------------------------------------------------------------
    logic r_active1;
    logic r_colon1;
    logic r_hs1;
    logic r_vs1;

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            d         <= c_NO_DIGIT;
            r_active1 <= 1'b0;
            r_colon1  <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
        end else begin
            x         <= w_x;
            y         <= w_y;
            d         <= w_d;
            r_active1 <= w_active;
            r_colon1  <= w_colon;
            r_hs1     <= w_hs;
            r_vs1     <= w_vs;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 registers: colour, with syncs delayed to stay aligned with it.
    // f arrives combinationally from this cycle's stage-1 x/y/d.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else begin
            hsync <= r_hs1;
            vsync <= r_vs1;
            if (!r_active1) begin
                rgb <= '0;
            end else if (f || r_colon1) begin
                rgb <= FG;
            end else begin
                rgb <= BG;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_driver
// Purpose  : Self-checking bench for digit_scan_driver. A schedule of
//            expected outputs (keyed by absolute clock count) is queued up
//            front; a negedge monitor pops and compares each entry when its
//            cycle comes. A model renderer drives f from x/y/d.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_driver;

    localparam int          X0 = 160;
    localparam int          Y0 = 200;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;

    localparam longint FRAME = 420000;          // 800 x 525 pixels
    localparam longint B0    = 3;               // last edge of power-on reset
    localparam longint B1    = B0 + 160301;     // reset edge of the mid-frame reset
    localparam longint T_END = B1 + FRAME + 200000;

    localparam int S_X = 0, S_Y = 1, S_D = 2, S_HS = 3, S_VS = 4, S_RGB = 5;
    localparam int S_BLANK = 6, S_HSLOW = 7, S_VSLOW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] time_bcd = 24'h000000;
    logic        f;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  d;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    longint t = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int blank_bad = 0;
    int hs_low = 0;
    int vs_low = 0;

    typedef struct packed {
        longint due;
        int     sig;
        int     exp;
        int     h;
        int     v;
    } item_t;

    item_t q[$];

    digit_scan_driver #(.X0(X0), .Y0(Y0), .FG(FG), .BG(BG)) dut (
        .clk      (clk),
        .rst      (rst),
        .time_bcd (time_bcd),
        .f        (f),
        .x        (x),
        .y        (y),
        .d        (d),
        .hsync    (hsync),
        .vsync    (vsync),
        .rgb      (rgb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) t <= t + 1;

    // Model renderer: a fixed checker-ish pattern, dark for non-BCD codes.
    function automatic logic model_f(input logic [9:0] xx, input logic [9:0] yy, input logic [3:0] dd);
        return (dd <= 4'd9) && (xx[3] ^ yy[2] ^ dd[0]);
    endfunction

    assign f = model_f(x, y, d);

    function automatic string sig_name(input int s);
        case (s)
            S_X:     return "x";
            S_Y:     return "y";
            S_D:     return "d";
            S_HS:    return "hsync";
            S_VS:    return "vsync";
            S_RGB:   return "rgb";
            S_BLANK: return "blank_rgb_nonzero";
            S_HSLOW: return "hsync_low_clocks";
            S_VSLOW: return "vsync_low_clocks";
            default: return "unknown";
        endcase
    endfunction

    // Insert keeping the queue ordered by due cycle.
    function automatic void push(input longint due, input int sig, input int exp, input int h, input int v);
        item_t it;
        int    pos;
        it.due = due; it.sig = sig; it.exp = exp; it.h = h; it.v = v;
        pos = q.size();
        while (pos > 0 && q[pos-1].due > due) pos--;
        q.insert(pos, it);
    endfunction

    // Stage-1 outputs for pixel (h,v) appear 1 clock after the counter value.
    function automatic void probe1(input longint base, input int h, input int v, input int sig, input int exp);
        push(base + longint'(v) * 800 + longint'(h) + 1, sig, exp, h, v);
    endfunction

    // Stage-2 outputs (rgb, syncs) appear 2 clocks after the counter value.
    function automatic void probe2(input longint base, input int h, input int v, input int sig, input int exp);
        push(base + longint'(v) * 800 + longint'(h) + 2, sig, exp, h, v);
    endfunction

    function automatic void probe_cell(input longint base, input int h, input int v,
                                       input int ex, input int ey, input int ed);
        probe1(base, h, v, S_X, ex);
        probe1(base, h, v, S_Y, ey);
        probe1(base, h, v, S_D, ed);
        probe2(base, h, v, S_RGB, model_f(10'(ex), 10'(ey), 4'(ed)) ? int'(FG) : int'(BG));
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        longint      p;
        int          ph;
        int          pv;
        item_t       it;
        logic [31:0] act;

        // Frame-wide statistics over frame 0 after the mid-frame reset.
        if (t >= B1 + 2 && t < B1 + 2 + FRAME) begin
            p  = t - B1 - 2;
            ph = int'(p % 800);
            pv = int'(p / 800);
            if ((ph >= 640 || pv >= 480) && rgb !== 12'h000) blank_bad++;
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
        end

        while (q.size() > 0 && (q[0].due <= t || t >= T_END)) begin
            it = q.pop_front();
            case (it.sig)
                S_X:     act = {22'b0, x};
                S_Y:     act = {22'b0, y};
                S_D:     act = {28'b0, d};
                S_HS:    act = {31'b0, hsync};
                S_VS:    act = {31'b0, vsync};
                S_RGB:   act = {20'b0, rgb};
                S_BLANK: act = blank_bad;
                S_HSLOW: act = hs_low;
                S_VSLOW: act = vs_low;
                default: act = 32'hDEAD_BEEF;
            endcase
            n_cmp++;
            if (it.due != t || act !== 32'(it.exp)) begin
                n_bad++;
                $display("FAIL %s@(%0d,%0d) actual=%0h required=%0h due=%0d now=%0d",
                         sig_name(it.sig), it.h, it.v, act, it.exp, it.due, t);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus and expected schedule
    // ------------------------------------------------------------------------
    task automatic wait_t(input longint k);
        while (t < k) @(negedge clk);
    endtask

    initial begin
        int starts [6];
        int f0_d   [6];
        int f1_d   [6];
        starts = '{X0, X0+48, X0+112, X0+160, X0+224, X0+272};
        f0_d   = '{0, 0, 0, 0, 0, 0};
        f1_d   = '{9, 9, 3, 9, 9, 10};

        // Power-on reset values.
        push(B0, S_X, 0, 0, 0);     push(B0, S_Y, 0, 0, 0);   push(B0, S_D, 15, 0, 0);
        push(B0, S_HS, 1, 0, 0);    push(B0, S_VS, 1, 0, 0);  push(B0, S_RGB, 0, 0, 0);

        // Line 0 hsync edges.
        probe2(B0, 655, 0, S_HS, 1);  probe2(B0, 656, 0, S_HS, 0);
        probe2(B0, 751, 0, S_HS, 0);  probe2(B0, 752, 0, S_HS, 1);

        // Cell 0 right edge on the top row.
        probe1(B0, X0+39, Y0, S_X, 39); probe1(B0, X0+39, Y0, S_Y, 0); probe1(B0, X0+39, Y0, S_D, 0);
        probe1(B0, X0+40, Y0, S_D, 15); probe1(B0, X0+40, Y0, S_X, 0);

        // Last stage-1 value before the mid-frame reset: inside cell 2.
        probe1(B0, 299, 200, S_D, 0);   probe1(B0, 299, 200, S_X, 27);

        // Values right after the mid-frame reset edge.
        push(B1, S_X, 0, 300, 200);  push(B1, S_Y, 0, 300, 200); push(B1, S_D, 15, 300, 200);
        push(B1, S_HS, 1, 300, 200); push(B1, S_VS, 1, 300, 200); push(B1, S_RGB, 0, 300, 200);
        push(B1 + 657, S_HS, 1, 655, 0);
        push(B1 + 658, S_HS, 0, 656, 0);

        // Frame 0 after restart: vsync edges.
        for (int v = 489; v <= 492; v++) probe2(B1, 0, v, S_VS, (v == 490 || v == 491) ? 0 : 1);

        // Frame 0: all cells still show the reset-latched zeros.
        for (int i = 0; i < 6; i++) probe1(B1, starts[i] + 5, Y0+10, S_D, f0_d[i]);
        probe_cell(B1, X0+117, Y0+10, 5, 10, 0);
        probe_cell(B1, X0+120, Y0+10, 8, 10, 0);
        probe1(B1, X0, Y0+79, S_Y, 79);  probe1(B1, X0, Y0+79, S_D, 0);
        probe1(B1, X0, Y0+80, S_D, 15);  probe1(B1, X0, Y0+80, S_Y, 0);
        probe1(B1, X0-1, Y0+10, S_D, 15);
        probe_cell(B1, X0+41, Y0+10, 0, 0, 15);

        // Whole-frame statistics.
        push(B1 + 2 + FRAME, S_BLANK, 0, -1, -1);
        push(B1 + 2 + FRAME, S_HSLOW, 96 * 525, -1, -1);
        push(B1 + 2 + FRAME, S_VSLOW, 2 * 800, -1, -1);

        // Frame 1: digits captured exactly at the latch cycle.
        for (int i = 0; i < 6; i++) probe1(B1 + FRAME, starts[i] + 5, Y0+10, S_D, f1_d[i]);
        probe_cell(B1 + FRAME, X0+117, Y0+10, 5, 10, 3);
        probe_cell(B1 + FRAME, X0+120, Y0+10, 8, 10, 3);
        probe_cell(B1 + FRAME, X0+277, Y0+10, 5, 10, 10);
`ifdef COLON_EN
        probe2(B1 + FRAME, X0+100, Y0+24, S_RGB, int'(FG));
`else
        probe2(B1 + FRAME, X0+100, Y0+24, S_RGB, int'(BG));
`endif

        // Drive.
        wait_t(B0);            rst = 1'b0;
        wait_t(B1 - 1);        rst = 1'b1;              // counters at (300,200)
        wait_t(B1);            rst = 1'b0;
        wait_t(B1 + 80000);    time_bcd = 24'h999999;   // v = 100 of frame 0
        wait_t(B1 + 384000);   time_bcd = 24'h99399A;   // present only at the latch edge
        wait_t(B1 + 384001);   time_bcd = 24'h999999;

        while (q.size() > 0 && t <= T_END) @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_scan_driver.md
# digit_scan_driver

Raster scan driver for the stopwatch display: generates 640x480@60 VGA timing from the pixel clock and, per pixel, drives cell-local coordinates and a digit code to the glyph renderer. It consumes the renderer's combinational lit flag and produces the registered RGB output. The six-digit time display is MM:SS:CC, and the BCD input is latched once per frame so the displayed value never tears.

## Interface
Parameters:
- X0, 160: left edge of digit 0, in screen pixels.
- Y0, 200: top edge of the digit row.
- FG, 12'hFFF: foreground RGB444 colour.
- BG, 12'h000: background RGB444 colour inside the active area.

Ports:
- clk  in  1  25 MHz pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- time_bcd  in  24  six BCD digits {M1,M0,S1,S0,C1,C0}; M1 is the leftmost digit.
- f  in  1  lit flag from the glyph renderer; combinational function of x, y, d.
- x  out  10  cell-local x, 0..39; 0 outside any cell.
- y  out  10  cell-local y, 0..79; 0 outside any cell.
- d  out  4  digit code for the current cell; 4'hF outside any cell (renderer draws nothing).
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- rgb  out  12  pixel colour; 0 during blanking.

## Operation
- h counter runs 0..799 and wraps to 0. v counter increments when h wraps, runs 0..524, then wraps to 0.
- Active area: h<640 and v<480.
- Horizontal timing: sync low for h in 656..751.
- Vertical timing: sync low for v in 490..491.
- Cell i (i=0..5, left to right) spans x offsets X0+{0,48,112,160,224,272} through +39, and Y0..Y0+79.
  - Inside cell i: x = h - start_i, y = v - Y0, d = latched digit i.
- Frame latch: time_bcd is captured when h==0 and v==480, i.e. the first blank line. Digits outside the cell area between latches are ignored. A non-BCD nibble (>9) passes through unchanged, and the renderer blanks that cell.
- Pixel colour: rgb = FG if active and (f or colon_hit), BG if active otherwise, 0 if blanking.
- Reset values:
  - h = 0, v = 0, latched digits = 0.
  - x = 0, y = 0, d = 4'hF.
  - hsync = 1, vsync = 1, rgb = 0.
- Reset asserted mid-frame restarts the frame at (0,0) on the next edge. No partial line is emitted after reset.

## Timing
- Stage 0: h and v counters.
- Stage 1 (registered): x, y, d, the active flag, colon_hit, and sync values decoded from the stage-0 h/v. The renderer computes f combinationally from stage-1 outputs within the same cycle.
- Stage 2 (registered): rgb.
- hsync and vsync are delayed 2 cycles so they align with rgb.
- Total latency is 2 clocks from counter value to rgb, hsync and vsync.
- Stage-1 x/y/d lead rgb by exactly 1 cycle. The integrator must not add registers between this block's x/y/d outputs and the renderer's f output.
- A time_bcd change is visible at the first active pixel of the frame following the next latch point. A change at the latch cycle itself is captured.

## Configuration
- COLON_EN defined:
  - Two 8x8 colon dots per separator are drawn in FG.
  - Separator 1: x X0+96..X0+103.
  - Separator 2: x X0+208..X0+215.
  - Both separators: y Y0+20..Y0+27 and Y0+52..Y0+59.
  - colon_hit is computed in stage 1.
- COLON_EN undefined: colon_hit is tied to 0; the separator gaps show BG. Cell positions are unchanged.

## Test plan
- Reset, then run one frame:
  - hsync low exactly 96 clocks per line, period 800.
  - vsync low exactly 2 lines, period 525 lines.
  - rgb = 0 in every blanking pixel.
- time_bcd=24'h123456; probe pixel (X0+112+5, Y0+10), with the delay applied:
  - x=5, y=10, d=3.
  - rgb equals FG or BG according to f from a model renderer.
- Probe pixel (X0+41, Y0+10) with COLON_EN undefined: d=4'hF, x=0, y=0, rgb=BG.
- Change time_bcd from 24'h000000 to 24'h999999 mid-frame at v=100:
  - The current frame still shows d=0 in all cells.
  - The next frame shows d=9.
- COLON_EN defined; probe pixel (X0+100, Y0+24): rgb=FG irrespective of f.
- Assert rst for 1 cycle at h=300, v=200:
  - Outputs take their reset values next cycle.
  - The counter restarts from (0,0).
  - The first hsync low edge occurs 656+2 clocks after rst deasserts.
